// File: rtl/uart_dbg_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART debug bridge.
package uart_dbg_pkg;

   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_REQ    = 3'd3,
      ST_ACC    = 3'd4,
      ST_WAITRD = 3'd5,
      ST_SEND   = 3'd6,
      ST_DRAIN  = 3'd7
   } state_e;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WR) || (b == OP_RD);
   endfunction

endpackage

// File: rtl/dbg_tx_seq.sv
// Response shifter: holds up to four bytes and feeds them LSB-first to uart_tx,
// one tx_start per idle period of tx_ready.
module dbg_tx_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [2:0]  load_cnt_i,
   input  logic [31:0] load_data_i,
   input  logic        tx_ready_i,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   output logic        empty_o,
   output logic        busy_o
);

   logic [2:0]  cnt_q,   cnt_d;
   logic [31:0] shift_q, shift_d;
   logic        start_q, start_d;
   logic [7:0]  data_q,  data_d;
   logic        issue;

   // uart_tx only drops tx_ready the cycle after tx_start, so the cycle in
   // which tx_start is high must not issue another byte.
   assign issue = (cnt_q != 3'd0) && tx_ready_i && !start_q;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      start_d = 1'b0;
      if (load_i) begin
         cnt_d   = load_cnt_i;
         shift_d = load_data_i;
      end else if (issue) begin
         start_d = 1'b1;
         data_d  = shift_q[7:0];
         shift_d = {8'h00, shift_q[31:8]};
         cnt_d   = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 3'd0;
         shift_q <= 32'h0;
         start_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         start_q <= start_d;
         data_q  <= data_d;
      end
   end

   assign tx_start_o = start_q;
   assign tx_data_o  = data_q;
   assign empty_o    = (cnt_q == 3'd0);
   assign busy_o     = start_q;

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART-driven xbus initiator: parses W/R commands, stalls the CPU, performs one
// xbus access and answers with an ACK byte or the read word through uart_tx.
module uart_dbg_bridge
   import uart_dbg_pkg::*;
#(
   parameter int unsigned RD_LAT  = 0,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_end,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        halt_req,
   input  logic        halt_gnt,
   output logic        xbus_cs,
   output logic        xbus_we,
   output logic [3:0]  xbus_be,
   output logic [31:0] xbus_addr,
   output logic [31:0] xbus_wdata,
   input  logic [31:0] xbus_rdata
);

   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam int unsigned   LW       = $clog2(RD_LAT + 2);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT);

   state_e        state_q, state_d;
   logic [1:0]    cnt_q,    cnt_d;
   logic [TW-1:0] tmo_q,    tmo_d;
   logic [LW-1:0] lat_q,    lat_d;
   logic          opwr_q,   opwr_d;
   logic [31:0]   addr_q,   addr_d;
   logic [31:0]   wdata_q,  wdata_d;
   logic [31:0]   xaddr_q,  xaddr_d;
   logic [31:0]   xwdata_q, xwdata_d;
   logic          xwe_q,    xwe_d;
   logic [3:0]    xbe_q,    xbe_d;

   logic          seq_load;
   logic [2:0]    seq_cnt;
   logic [31:0]   seq_data;
   logic          seq_empty;
   logic          seq_busy;
   logic          tmo_hit;

   assign tmo_hit = (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A byte arriving in the same cycle as timeout expiry is still accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_end && is_opcode(rx_data)) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (rx_end) begin
               if (cnt_q == 2'd3) state_d = opwr_q ? ST_DATA : ST_REQ;
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_end) begin
               if (cnt_q == 2'd3) state_d = ST_REQ;
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (halt_gnt) state_d = ST_ACC;
         end
         ST_ACC: begin
            state_d = (opwr_q || (RD_LAT == 0)) ? ST_SEND : ST_WAITRD;
         end
         ST_WAITRD: begin
            if (lat_q == LAT_LAST) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (seq_empty) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (tx_ready && !seq_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The read word is taken straight from xbus_rdata into the response
   // shifter on the cycle the FSM leaves ACC/WAITRD for SEND.
   always_comb begin
      halt_req = (state_q == ST_REQ) || (state_q == ST_ACC) || (state_q == ST_WAITRD)
              || (state_q == ST_SEND) || (state_q == ST_DRAIN);
      xbus_cs  = (state_q == ST_ACC);
      seq_load = 1'b0;
      seq_cnt  = 3'd0;
      seq_data = 32'h0;
      if ((state_q == ST_IDLE) && rx_end && !is_opcode(rx_data)) begin
         seq_load = 1'b1;
         seq_cnt  = 3'd1;
         seq_data = {24'h0, NAK};
      end else if ((state_d == ST_SEND) && (state_q != ST_SEND)) begin
         seq_load = 1'b1;
         seq_cnt  = opwr_q ? 3'd1 : 3'd4;
         seq_data = opwr_q ? {24'h0, ACK} : xbus_rdata;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      tmo_d    = '0;
      lat_d    = lat_q;
      opwr_d   = opwr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      xaddr_d  = xaddr_q;
      xwdata_d = xwdata_q;
      xwe_d    = xwe_q;
      xbe_d    = xbe_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_end && is_opcode(rx_data)) begin
               opwr_d = (rx_data == OP_WR);
               cnt_d  = 2'd0;
            end
         end
         ST_ADDR: begin
            if (rx_end) begin
               addr_d[8*cnt_q +: 8] = rx_data;
               cnt_d                = cnt_q + 2'd1;
            end else if (!tmo_hit) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_DATA: begin
            if (rx_end) begin
               wdata_d[8*cnt_q +: 8] = rx_data;
               cnt_d                 = cnt_q + 2'd1;
            end else if (!tmo_hit) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_REQ: begin
            // xbus outputs only change here, so they hold steady around ACC.
            if (halt_gnt) begin
               xaddr_d  = addr_q;
               xwdata_d = wdata_q;
               xwe_d    = opwr_q;
               xbe_d    = 4'hF;
            end
         end
         ST_ACC: begin
            lat_d = LW'(1);
         end
         ST_WAITRD: begin
            lat_d = lat_q + LW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         tmo_q    <= '0;
         lat_q    <= '0;
         opwr_q   <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         xaddr_q  <= 32'h0;
         xwdata_q <= 32'h0;
         xwe_q    <= 1'b0;
         xbe_q    <= 4'h0;
      end else begin
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         lat_q    <= lat_d;
         opwr_q   <= opwr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         xaddr_q  <= xaddr_d;
         xwdata_q <= xwdata_d;
         xwe_q    <= xwe_d;
         xbe_q    <= xbe_d;
      end
   end

   assign xbus_addr  = xaddr_q;
   assign xbus_wdata = xwdata_q;
   assign xbus_we    = xwe_q;
   assign xbus_be    = xbe_q;

   dbg_tx_seq u_tx_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (seq_load),
      .load_cnt_i  (seq_cnt),
      .load_data_i (seq_data),
      .tx_ready_i  (tx_ready),
      .tx_start_o  (tx_start),
      .tx_data_o   (tx_data),
      .empty_o     (seq_empty),
      .busy_o      (seq_busy)
   );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge with small models of uart_tx, the CPU
// halt handshake and a synchronous (one-cycle latency) xbus slave.
module tb_uart_dbg_bridge;

   localparam int TXLEN = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_end = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b1;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        halt_req;
   logic        halt_gnt;
   logic        xbus_cs;
   logic        xbus_we;
   logic [3:0]  xbus_be;
   logic [31:0] xbus_addr;
   logic [31:0] xbus_wdata;
   logic [31:0] xbus_rdata;

   logic [1:0]  gnt_pipe = 2'b00;
   logic        gnt_block = 1'b0;
   logic [31:0] slave_data = 32'h0;
   logic [31:0] rdata_r = 32'hBAD0BAD0;

   int          tx_busy = 0;
   int          tx_n = 0;
   int          tx_viol = 0;
   logic [7:0]  tx_log [64];
   int          acc_n = 0;
   logic        last_we = 1'b0;
   logic [3:0]  last_be = 4'h0;
   logic [31:0] last_addr = 32'h0;
   logic [31:0] last_wdata = 32'h0;
   int          cyc = 0;
   int          cs_cycles = 0;
   int          cs_nognt = 0;
   int          cs_cyc = 0;
   int          gnt_rise_cyc = 0;
   int          halt_rise_n = 0;
   int          halt_fall_n = 0;
   int          fall_bad = 0;
   logic        halt_prev = 1'b0;
   logic        gnt_prev = 1'b0;

   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   uart_dbg_bridge #(.RD_LAT(1), .TIMEOUT(100)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_end     (rx_end),
      .rx_data    (rx_data),
      .tx_ready   (tx_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .halt_req   (halt_req),
      .halt_gnt   (halt_gnt),
      .xbus_cs    (xbus_cs),
      .xbus_we    (xbus_we),
      .xbus_be    (xbus_be),
      .xbus_addr  (xbus_addr),
      .xbus_wdata (xbus_wdata),
      .xbus_rdata (xbus_rdata)
   );

   assign halt_gnt   = gnt_pipe[1] & ~gnt_block;
   assign xbus_rdata = rdata_r;

   // CPU grants two cycles after the request; gnt_block models a slow CPU.
   always @(posedge clk) gnt_pipe <= {gnt_pipe[0], halt_req};

   // uart_tx: drops tx_ready the cycle after tx_start, busy for TXLEN cycles.
   always @(posedge clk) begin
      if (tx_start) begin
         if (!tx_ready) tx_viol <= tx_viol + 1;
         tx_log[tx_n % 64] <= tx_data;
         tx_n     <= tx_n + 1;
         tx_ready <= 1'b0;
         tx_busy  <= TXLEN;
      end else if (tx_busy != 0) begin
         tx_busy <= tx_busy - 1;
         if (tx_busy == 1) tx_ready <= 1'b1;
      end
   end

   // Synchronous slave: data valid only in the cycle after xbus_cs.
   always @(posedge clk) begin
      rdata_r <= xbus_cs ? slave_data : 32'hBAD0BAD0;
      if (xbus_cs) begin
         acc_n      <= acc_n + 1;
         last_we    <= xbus_we;
         last_be    <= xbus_be;
         last_addr  <= xbus_addr;
         last_wdata <= xbus_wdata;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (xbus_cs) begin
         cs_cycles <= cs_cycles + 1;
         cs_cyc    <= cyc;
         if (!halt_gnt) cs_nognt <= cs_nognt + 1;
      end
      if (halt_gnt && !gnt_prev) gnt_rise_cyc <= cyc;
      if (halt_req && !halt_prev) halt_rise_n <= halt_rise_n + 1;
      if (rst_n && halt_prev && !halt_req) begin
         halt_fall_n <= halt_fall_n + 1;
         if (!tx_ready) fall_bad <= fall_bad + 1;
      end
      halt_prev <= halt_req;
      gnt_prev  <= halt_gnt;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_end  = 1'b1;
      @(posedge clk); #1;
      rx_end  = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_w32(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic wait_done(input int tx0, input int nbytes, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ((tx_n - tx0) >= nbytes && !halt_req && tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s: timed out, tx bytes got %0d need %0d", name, tx_n - tx0, nbytes);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (tx_start !== 1'b0)       begin bad++; $display("[TB] FAIL rst_tx_start: got %b need 0", tx_start); end
      total++; if (tx_data !== 8'h00)       begin bad++; $display("[TB] FAIL rst_tx_data: got %h need 00", tx_data); end
      total++; if (halt_req !== 1'b0)       begin bad++; $display("[TB] FAIL rst_halt_req: got %b need 0", halt_req); end
      total++; if (xbus_cs !== 1'b0)        begin bad++; $display("[TB] FAIL rst_cs: got %b need 0", xbus_cs); end
      total++; if (xbus_we !== 1'b0)        begin bad++; $display("[TB] FAIL rst_we: got %b need 0", xbus_we); end
      total++; if (xbus_be !== 4'h0)        begin bad++; $display("[TB] FAIL rst_be: got %h need 0", xbus_be); end
      total++; if (xbus_addr !== 32'h0)     begin bad++; $display("[TB] FAIL rst_addr: got %h need 0", xbus_addr); end
      total++; if (xbus_wdata !== 32'h0)    begin bad++; $display("[TB] FAIL rst_wdata: got %h need 0", xbus_wdata); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write();
      int tx0 = tx_n, acc0 = acc_n, cs0 = cs_cycles, hf0 = halt_fall_n, fb0 = fall_bad;
      send_byte(8'h57);
      send_w32(32'h20000010);
      send_w32(32'hDEADBEEF);
      wait_done(tx0, 1, "wr_done");
      total++; if ((acc_n - acc0) !== 1)      begin bad++; $display("[TB] FAIL wr_acc_count: got %0d need 1", acc_n - acc0); end
      total++; if ((cs_cycles - cs0) !== 1)   begin bad++; $display("[TB] FAIL wr_cs_cycles: got %0d need 1", cs_cycles - cs0); end
      total++; if (last_we !== 1'b1)          begin bad++; $display("[TB] FAIL wr_we: got %b need 1", last_we); end
      total++; if (last_be !== 4'hF)          begin bad++; $display("[TB] FAIL wr_be: got %h need f", last_be); end
      total++; if (last_addr !== 32'h20000010) begin bad++; $display("[TB] FAIL wr_addr: got %h need 20000010", last_addr); end
      total++; if (last_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wr_wdata: got %h need deadbeef", last_wdata); end
      total++; if ((tx_n - tx0) !== 1)        begin bad++; $display("[TB] FAIL wr_tx_count: got %0d need 1", tx_n - tx0); end
      total++; if (tx_log[tx0 % 64] !== 8'h06) begin bad++; $display("[TB] FAIL wr_ack: got %h need 06", tx_log[tx0 % 64]); end
      total++; if ((halt_fall_n - hf0) !== 1 || fall_bad !== fb0)
         begin bad++; $display("[TB] FAIL wr_halt_fall: falls %0d early %0d need 1/0", halt_fall_n - hf0, fall_bad - fb0); end
   endtask

   task automatic test_read(input logic [31:0] addr, input logic [31:0] data, input string name);
      int tx0 = tx_n, acc0 = acc_n, cs0 = cs_cycles, tv0 = tx_viol;
      slave_data = data;
      send_byte(8'h52);
      send_w32(addr);
      wait_done(tx0, 4, name);
      total++; if ((acc_n - acc0) !== 1)    begin bad++; $display("[TB] FAIL %s_acc_count: got %0d need 1", name, acc_n - acc0); end
      total++; if ((cs_cycles - cs0) !== 1) begin bad++; $display("[TB] FAIL %s_cs_cycles: got %0d need 1", name, cs_cycles - cs0); end
      total++; if (last_we !== 1'b0)        begin bad++; $display("[TB] FAIL %s_we: got %b need 0", name, last_we); end
      total++; if (last_addr !== addr)      begin bad++; $display("[TB] FAIL %s_addr: got %h need %h", name, last_addr, addr); end
      total++; if ((tx_n - tx0) !== 4)      begin bad++; $display("[TB] FAIL %s_tx_count: got %0d need 4", name, tx_n - tx0); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (tx_log[(tx0 + k) % 64] !== data[8*k +: 8])
            begin bad++; $display("[TB] FAIL %s_byte%0d: got %h need %h", name, k, tx_log[(tx0 + k) % 64], data[8*k +: 8]); end
      end
      total++; if (tx_viol !== tv0) begin bad++; $display("[TB] FAIL %s_tx_while_busy: got %0d need 0", name, tx_viol - tv0); end
   endtask

   task automatic test_bad_opcode();
      int tx0 = tx_n, acc0 = acc_n, hr0 = halt_rise_n;
      send_byte(8'h41);
      wait_done(tx0, 1, "nak_done");
      total++; if ((tx_n - tx0) !== 1)       begin bad++; $display("[TB] FAIL nak_tx_count: got %0d need 1", tx_n - tx0); end
      total++; if (tx_log[tx0 % 64] !== 8'h15) begin bad++; $display("[TB] FAIL nak_byte: got %h need 15", tx_log[tx0 % 64]); end
      total++; if ((halt_rise_n - hr0) !== 0) begin bad++; $display("[TB] FAIL nak_halt: got %0d need 0", halt_rise_n - hr0); end
      total++; if ((acc_n - acc0) !== 0)     begin bad++; $display("[TB] FAIL nak_acc: got %0d need 0", acc_n - acc0); end
      test_read(32'h00000103, 32'hCAFEF00D, "rd_after_nak");
   endtask

   task automatic test_timeout();
      int tx0 = tx_n, acc0 = acc_n, hr0 = halt_rise_n;
      send_byte(8'h57);
      send_byte(8'h10);
      send_byte(8'h00);
      repeat (150) @(negedge clk);
      total++; if ((tx_n - tx0) !== 0)        begin bad++; $display("[TB] FAIL tmo_silent: got %0d bytes need 0", tx_n - tx0); end
      total++; if ((halt_rise_n - hr0) !== 0) begin bad++; $display("[TB] FAIL tmo_halt: got %0d need 0", halt_rise_n - hr0); end
      total++; if ((acc_n - acc0) !== 0)      begin bad++; $display("[TB] FAIL tmo_acc: got %0d need 0", acc_n - acc0); end
      test_read(32'h00000000, 32'hA5A55A5A, "rd_after_tmo");
   endtask

   task automatic test_grant_stall();
      int tx0 = tx_n, acc0 = acc_n, cs0 = cs_cycles;
      gnt_block = 1'b1;
      send_byte(8'h57);
      send_w32(32'h00000008);
      send_w32(32'h11223344);
      repeat (50) @(negedge clk);
      total++; if ((cs_cycles - cs0) !== 0) begin bad++; $display("[TB] FAIL stall_cs: got %0d need 0", cs_cycles - cs0); end
      total++; if (halt_req !== 1'b1)       begin bad++; $display("[TB] FAIL stall_halt_req: got %b need 1", halt_req); end
      @(posedge clk); #1;
      gnt_block = 1'b0;
      wait_done(tx0, 1, "stall_done");
      total++; if ((cs_cycles - cs0) !== 1) begin bad++; $display("[TB] FAIL stall_cs_cycles: got %0d need 1", cs_cycles - cs0); end
      total++; if ((cs_cyc - gnt_rise_cyc) !== 1)
         begin bad++; $display("[TB] FAIL stall_cs_delay: got %0d need 1", cs_cyc - gnt_rise_cyc); end
      total++; if ((acc_n - acc0) !== 1 || last_addr !== 32'h8 || last_wdata !== 32'h11223344)
         begin bad++; $display("[TB] FAIL stall_access: n=%0d addr=%h wdata=%h need 1/8/11223344", acc_n - acc0, last_addr, last_wdata); end
      total++; if (tx_log[tx0 % 64] !== 8'h06) begin bad++; $display("[TB] FAIL stall_ack: got %h need 06", tx_log[tx0 % 64]); end
   endtask

   task automatic test_reset_mid_send();
      int tx0 = tx_n, tx1, acc0;
      bit seen = 1'b0;
      slave_data = 32'h0BADF00D;
      send_byte(8'h52);
      send_w32(32'h00000040);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ((tx_n - tx0) >= 2) begin
            seen = 1'b1;
            break;
         end
      end
      total++; if (!seen) begin bad++; $display("[TB] FAIL midrst_reach_send: tx bytes got %0d need 2", tx_n - tx0); end
      rst_n = 1'b0;
      #1;
      total++; if (halt_req !== 1'b0 || tx_start !== 1'b0 || xbus_cs !== 1'b0)
         begin bad++; $display("[TB] FAIL midrst_ctrl: halt=%b start=%b cs=%b need 000", halt_req, tx_start, xbus_cs); end
      total++; if (xbus_addr !== 32'h0 || xbus_be !== 4'h0 || tx_data !== 8'h00)
         begin bad++; $display("[TB] FAIL midrst_data: addr=%h be=%h txd=%h need 0", xbus_addr, xbus_be, tx_data); end
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      tx1  = tx_n;
      acc0 = acc_n;
      repeat (3) @(posedge clk);
      send_byte(8'h57);
      send_w32(32'h30000004);
      send_w32(32'h01020304);
      wait_done(tx1, 1, "midrst_next");
      total++; if ((acc_n - acc0) !== 1 || last_addr !== 32'h30000004 || last_wdata !== 32'h01020304 || last_we !== 1'b1)
         begin bad++; $display("[TB] FAIL midrst_next_access: n=%0d addr=%h wdata=%h we=%b", acc_n - acc0, last_addr, last_wdata, last_we); end
      total++; if ((tx_n - tx1) !== 1 || tx_log[tx1 % 64] !== 8'h06)
         begin bad++; $display("[TB] FAIL midrst_next_ack: n=%0d byte=%h need 1/06", tx_n - tx1, tx_log[tx1 % 64]); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(32'h00000004, 32'h12345678, "rd");
      test_bad_opcode();
      test_timeout();
      test_grant_stall();
      test_reset_mid_send();
      total++; if (cs_nognt !== 0) begin bad++; $display("[TB] FAIL cs_without_gnt: got %0d need 0", cs_nognt); end
      total++; if (tx_viol !== 0)  begin bad++; $display("[TB] FAIL tx_start_while_busy: got %0d need 0", tx_viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
